// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and constants for the SPI master arbiter: FSM encoding, default
// gap/timeout settings and a constant-width helper.
package spi_master_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLaunch = 3'd1,
    StBusy   = 3'd2,
    StResp   = 3'd3,
    StGap    = 3'd4
  } arb_state_e;

  localparam int unsigned DefaultGapCycles     = 2;
  localparam int unsigned DefaultTimeoutCycles = 255;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned value);
    return (clog2(value) > 0) ? clog2(value) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping, returned as a one-hot grant plus its binary index.
module spi_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master among NUM_REQ requesters with round-robin arbitration.
// Optional BUSY watchdog is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter
  import spi_master_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned GAP_CYCLES     = DefaultGapCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        owner,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        timeout_err,
  output logic                      spi_start,
  output logic [DATA_W-1:0]         spi_tx,
  input  logic [DATA_W-1:0]         spi_rx,
  input  logic                      spi_done
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);
  localparam int unsigned GapW = idx_width(GAP_CYCLES + 1);
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);
  localparam arb_state_e AfterXfer = (GAP_CYCLES == 0) ? StIdle : StGap;

  arb_state_e state_q, state_d;
  logic [IdxW-1:0]    winner_q, winner_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [DATA_W-1:0]  spi_tx_q, spi_tx_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic               done_q, done_prev_q;
  logic               done_edge;
  logic               tmo_hit;
  logic               tmo_fire;

  logic [NUM_REQ-1:0] grant;
  logic [IdxW-1:0]    grant_idx;
  logic               grant_valid;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_arbiter (
    .req         (req),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // spi_done is registered twice so a level left high from an earlier
  // transfer never looks like a fresh completion.
  assign done_edge = done_q & ~done_prev_q;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = idx_width(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast =
      TmoW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [TmoW-1:0] tmo_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == StBusy) begin
      tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_hit = (state_q == StBusy) && (tmo_cnt_q == TmoLast);
`else
  // Watchdog compiled out; BUSY waits for the done edge indefinitely.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    spi_tx_d   = spi_tx_q;
    rsp_data_d = rsp_data_q;
    gap_cnt_d  = gap_cnt_q;
    tmo_fire   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          winner_d = grant_idx;
          owner_d  = grant;
          spi_tx_d = req_data[32'(grant_idx)*DATA_W +: DATA_W];
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        rr_ptr_d = (winner_q == LastIdx) ? '0 : winner_q + IdxW'(1);
        state_d  = StBusy;
      end
      StBusy: begin
        if (done_edge) begin
          rsp_data_d = spi_rx;
          state_d    = StResp;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          owner_d   = '0;
          gap_cnt_d = GapLoad;
          state_d   = AfterXfer;
        end
      end
      StResp: begin
        owner_d   = '0;
        gap_cnt_d = GapLoad;
        state_d   = AfterXfer;
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      winner_q    <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      spi_tx_q    <= '0;
      rsp_data_q  <= '0;
      gap_cnt_q   <= '0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      spi_tx_q    <= spi_tx_d;
      rsp_data_q  <= rsp_data_d;
      gap_cnt_q   <= gap_cnt_d;
      done_q      <= spi_done;
      done_prev_q <= done_q;
    end
  end

  // owner_q is the one-hot of the winner for the whole LAUNCH..RESP window.
  assign ack         = (state_q == StResp) ? owner_q : '0;
  assign timeout_err = tmo_fire ? owner_q : '0;
  assign owner       = owner_q;
  assign busy        = (state_q != StIdle);
  assign spi_start   = (state_q == StLaunch);
  assign spi_tx      = spi_tx_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter; the bench plays the SPI master side.
module tb_spi_master_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  rsp_data;
  logic [3:0]  owner;
  logic        busy;
  logic [3:0]  timeout_err;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx;
  logic        spi_done;

  int checks   = 0;
  int failures = 0;

  spi_master_arbiter #(
    .NUM_REQ        (4),
    .DATA_W         (8),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .rsp_data    (rsp_data),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err),
    .spi_start   (spi_start),
    .spi_tx      (spi_tx),
    .spi_rx      (spi_rx),
    .spi_done    (spi_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    reset    = 1'b1;
    req      = 4'b0000;
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(output logic [3:0] a, output bit ok);
    ok = 1'b0;
    a  = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        a  = ack;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done(input logic [7:0] rx);
    spi_rx   = rx;
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    #1;
    checks++;
    if (ack !== 4'b0 || owner !== 4'b0 || timeout_err !== 4'b0) begin
      failures++;
      $display("FAIL reset_vec ack=%b owner=%b tmo=%b exp all 0", ack, owner, timeout_err);
    end
    checks++;
    if (busy !== 1'b0 || spi_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl busy=%b start=%b exp 0 0", busy, spi_start);
    end
    checks++;
    if (rsp_data !== 8'h00 || spi_tx !== 8'h00) begin
      failures++;
      $display("FAIL reset_data rsp=%h tx=%h exp 00 00", rsp_data, spi_tx);
    end
    do_reset();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b exp 0", busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [3:0] a;
    do_reset();
    req_data = 32'h0000_00A5;
    req      = 4'b0001;
    wait_start(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_start got=none exp=pulse");
    end
    checks++;
    if (spi_tx !== 8'hA5 || owner !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_launch tx=%h owner=%b busy=%b exp A5 0001 1", spi_tx, owner, busy);
    end
    @(negedge clk);
    checks++;
    if (spi_start !== 1'b0) begin
      failures++;
      $display("FAIL single_onepulse start=%b exp 0", spi_start);
    end
    pulse_done(8'h3C);
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_early_ack ack=%b exp 0000", ack);
    end
    wait_ack(a, ok);
    checks++;
    if (!ok || a !== 4'b0001) begin
      failures++;
      $display("FAIL single_ack got=%b exp=0001", a);
    end
    checks++;
    if (rsp_data !== 8'h3C || owner !== 4'b0001) begin
      failures++;
      $display("FAIL single_resp rsp=%h owner=%b exp 3C 0001", rsp_data, owner);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (owner !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b1 || spi_tx !== 8'hA5) begin
      failures++;
      $display("FAIL single_gap owner=%b ack=%b busy=%b tx=%h exp 0000 0000 1 A5",
               owner, ack, busy, spi_tx);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_data !== 8'h3C) begin
      failures++;
      $display("FAIL single_idle busy=%b rsp=%h exp 0 3C", busy, rsp_data);
    end
  endtask

  task automatic test_rotation();
    bit ok;
    logic [3:0] a;
    logic [3:0] exp_oh;
    logic [7:0] exp_tx;
    int gap;
    do_reset();
    req_data = 32'h1312_1110;
    req      = 4'b1111;
    wait_start(ok);
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      exp_tx = 8'h10 + 8'(k % 4);
      checks++;
      if (!ok || owner !== exp_oh || spi_tx !== exp_tx) begin
        failures++;
        $display("FAIL rot_grant%0d owner=%b tx=%h exp %b %h", k, owner, spi_tx, exp_oh, exp_tx);
      end
      @(negedge clk);
      pulse_done(8'hC0 + 8'(k));
      wait_ack(a, ok);
      checks++;
      if (!ok || a !== exp_oh || rsp_data !== 8'hC0 + 8'(k)) begin
        failures++;
        $display("FAIL rot_ack%0d ack=%b rsp=%h exp %b %h", k, a, rsp_data, exp_oh, 8'hC0 + 8'(k));
      end
      if (k < 4) begin
        gap = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (spi_start === 1'b1) begin
            ok = 1'b1;
            break;
          end
          if (busy === 1'b1 && owner === 4'b0000) gap++;
        end
        checks++;
        if (gap != 2) begin
          failures++;
          $display("FAIL rot_gap%0d got=%0d exp=2", k, gap);
        end
      end
    end
    req = 4'b0000;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_late_req();
    bit ok;
    logic [3:0] a;
    int extra;
    do_reset();
    req_data = 32'h0000_5A00 | 32'h00A5_0000 >> 16;
    req_data = {8'h00, 8'h5A, 8'h00, 8'hA5};
    req      = 4'b0001;
    wait_start(ok);
    @(negedge clk);
    req = 4'b0101;
    @(negedge clk);
    pulse_done(8'h3C);
    wait_ack(a, ok);
    checks++;
    if (!ok || a !== 4'b0001) begin
      failures++;
      $display("FAIL late_ack0 got=%b exp=0001", a);
    end
    req = 4'b0100;
    wait_start(ok);
    checks++;
    if (!ok || owner !== 4'b0100 || spi_tx !== 8'h5A) begin
      failures++;
      $display("FAIL late_grant2 owner=%b tx=%h exp 0100 5A", owner, spi_tx);
    end
    @(negedge clk);
    pulse_done(8'h96);
    wait_ack(a, ok);
    checks++;
    if (!ok || a !== 4'b0100 || rsp_data !== 8'h96) begin
      failures++;
      $display("FAIL late_ack2 ack=%b rsp=%h exp 0100 96", a, rsp_data);
    end
    req   = 4'b0000;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1 || ack !== 4'b0000) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL late_dup got=%0d exp=0", extra);
    end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    logic [3:0] a;
    int early;
    do_reset();
    req_data = 32'h0000_00A5;
    req      = 4'b0001;
    wait_start(ok);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0 || owner !== 4'b0 || busy !== 1'b0 || spi_start !== 1'b0 ||
        spi_tx !== 8'h00 || rsp_data !== 8'h00 || timeout_err !== 4'b0) begin
      failures++;
      $display("FAIL rstmid_outs ack=%b owner=%b busy=%b start=%b tx=%h rsp=%h exp all 0",
               ack, owner, busy, spi_start, spi_tx, rsp_data);
    end
    @(negedge clk);
    reset = 1'b0;
    early = 0;
    ok    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) early++;
      if (spi_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || early != 0 || spi_tx !== 8'hA5) begin
      failures++;
      $display("FAIL rstmid_restart start=%b acks=%0d tx=%h exp 1 0 A5", ok, early, spi_tx);
    end
    @(negedge clk);
    pulse_done(8'h3C);
    wait_ack(a, ok);
    checks++;
    if (!ok || a !== 4'b0001 || rsp_data !== 8'h3C) begin
      failures++;
      $display("FAIL rstmid_ack ack=%b rsp=%h exp 0001 3C", a, rsp_data);
    end
    req = 4'b0000;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stale_done();
    bit ok;
    logic [3:0] a;
    int early;
    do_reset();
    spi_rx   = 8'h3C;
    spi_done = 1'b1;
    @(negedge clk);
    req_data = 32'h0000_00A5;
    req      = 4'b0001;
    wait_start(ok);
    early = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) early++;
    end
    checks++;
    if (!ok || early != 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stale_noack acks=%0d busy=%b exp 0 1", early, busy);
    end
    spi_done = 1'b0;
    @(negedge clk);
    pulse_done(8'h3C);
    wait_ack(a, ok);
    checks++;
    if (!ok || a !== 4'b0001 || rsp_data !== 8'h3C) begin
      failures++;
      $display("FAIL stale_ack ack=%b rsp=%h exp 0001 3C", a, rsp_data);
    end
    req = 4'b0000;
    repeat (5) @(negedge clk);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    logic [3:0] a;
    int tmo_at;
    int acks;
    logic [3:0] tmo_val;
    do_reset();
    req_data = {8'h00, 8'h00, 8'h77, 8'hA5};
    req      = 4'b0001;
    wait_start(ok);
    tmo_at  = 0;
    tmo_val = 4'b0000;
    acks    = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (ack !== 4'b0000) acks++;
      if (timeout_err !== 4'b0000 && tmo_at == 0) begin
        tmo_at  = c;
        tmo_val = timeout_err;
      end
    end
    checks++;
    if (tmo_at != 20 || tmo_val !== 4'b0001 || acks != 0) begin
      failures++;
      $display("FAIL tmo_pulse cycle=%0d val=%b acks=%0d exp 20 0001 0", tmo_at, tmo_val, acks);
    end
    req = 4'b0010;
    wait_start(ok);
    checks++;
    if (!ok || owner !== 4'b0010 || spi_tx !== 8'h77) begin
      failures++;
      $display("FAIL tmo_next owner=%b tx=%h exp 0010 77", owner, spi_tx);
    end
    @(negedge clk);
    pulse_done(8'h3C);
    wait_ack(a, ok);
    checks++;
    if (!ok || a !== 4'b0010 || rsp_data !== 8'h3C) begin
      failures++;
      $display("FAIL tmo_ack ack=%b rsp=%h exp 0010 3C", a, rsp_data);
    end
    req = 4'b0000;
    repeat (5) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_late_req();
    test_reset_mid_busy();
    test_stale_done();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
